chimp_board_loader: RTL and testbench
=====================================

# chimp_board_loader

Upstream sequencer for the chimp-test board. On a start request it picks the cell count from the current level and places numbers 1..N into distinct pseudo-random cells of the 8x8 board. It emits one write command per number over a valid/ready handshake to the board datapath, then signals completion so the game FSM can move to the show phase.

## Interface
- `SEED`, default 16'hACE1: LFSR reset value. Must be non-zero.
- `MIN_COUNT`, default 4: number of cells placed at level 0.
- `clk` in 1: system clock; all state changes on the rising edge.
- `iReset` in 1: synchronous, active-high reset.
- `iStart` in 1: begin a placement round; sampled only in IDLE.
- `iLevel` in 5: current level, latched on accepted `iStart`.
- `iWrReady` in 1: board datapath accepts the current write command.
- `oWrValid` out 1: write command valid.
- `oCellX` out 3: target column (matches board `randNum[2:0]`).
- `oCellY` out 3: target row (matches board `randNum[5:3]`).
- `oNum` out 5: number to store in the cell, 1..31.
- `oBusy` out 1: high in every state except IDLE.
- `oDone` out 1: one-cycle pulse after the last write is accepted.

## Operation
- **Count:**
  - `count = min(iLevel + MIN_COUNT, 31)`, computed at 6-bit width, then saturated.
  - `iLevel` of 27 or more gives 31.
- **LFSR:**
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Advances every cycle in every state, including IDLE and EMIT stalls.
  - Reset loads `SEED`.
- **Occupancy map:**
  - 64 bits, index = {y, x}.
  - All bits cleared on an accepted `iStart`.
  - The bit is set when a cell is committed in CHECK.
- **States:**
  - IDLE: outputs quiet. `iStart` → latch `count`, `num = 1`, clear map → PICK.
  - PICK: `idx <= lfsr[5:0]` → CHECK.
  - CHECK:
    - If `map[idx] == 0`: set `map[idx]`; register `oCellX = idx[2:0]`, `oCellY = idx[5:3]`, `oNum = num`; set `oWrValid = 1` → EMIT.
    - Otherwise: `idx <= idx + 1` (63 wraps to 0), stay in CHECK.
    - Termination is guaranteed because at most 31 of 64 cells are occupied, so a free cell is found within 32 cycles.
  - EMIT:
    - Hold `oWrValid`, `oCellX`, `oCellY`, `oNum` stable until `iWrReady` is high.
    - On the handshake cycle, `oWrValid` drops next cycle.
    - If `num == count` → DONE; otherwise `num++` → PICK.
  - DONE: `oDone = 1` for this cycle only → IDLE.
- **Other rules:**
  - `iStart` in any state other than IDLE is ignored. No queuing, no restart.
  - `iLevel` changes after `iStart` is accepted have no effect on the round in progress.
  - `iWrReady` outside EMIT is ignored.
  - Every emitted cell within a round is unique. `oNum` values run strictly 1..count in order.

## Timing
- **Reset values:**
  - state = IDLE, `oWrValid` = 0, `oCellX` = 0, `oCellY` = 0, `oNum` = 0.
  - `oBusy` = 0, `oDone` = 0, map = 0, lfsr = `SEED`.
- **Reset mid-round:** aborts immediately. No further writes, no `oDone` pulse.
- **Start-up latency:** `iStart` sampled at cycle 0 → PICK at 1, CHECK at 2, `oWrValid` high at cycle 3.
- **Per-number cost:** 3 cycles with `iWrReady` held high and no collision. Each collision adds 1 cycle. Each cycle of `iWrReady` low adds 1 cycle.
- **Completion:** `oDone` is asserted in the cycle after the last handshake, and `oBusy` is also high that cycle. `oBusy` falls the following cycle.
- **Minimum round length:** with 4 numbers, ready held high and no collisions, handshakes occur at cycles 3, 6, 9, 12, `oDone` at 13, IDLE at 14.
- **Back-to-back rounds:** `iStart` high during the DONE cycle is ignored. It must be presented in IDLE.

## Test plan
- **Basic round:** reset, `iLevel = 0`, pulse `iStart`, `iWrReady = 1` → exactly 4 handshakes with `oNum` 1, 2, 3, 4 and 4 distinct {Y, X}; `oDone` is a single pulse 1 cycle after the 4th handshake; `oBusy` is high from cycle 1 until `oDone`.
- **Saturation:** `iLevel = 30` → exactly 31 handshakes, `oNum` 1..31, all cells distinct (scoreboard over the 64-bit map).
- **Backpressure:** `iLevel = 2`, hold `iWrReady` low for 7 cycles after each `oWrValid` rises → outputs bit-stable while stalled; 6 writes total; no number skipped or duplicated.
- **Collision and wrap:** force `idx = 63` into CHECK with cell 63 pre-occupied (via an earlier write in the same round, seeded by bench `SEED` search) → next probe is cell 0; command emitted for the first free index at or after the wrap.
- **Start and reset robustness:**
  - Pulse `iStart` again mid-round, and change `iLevel` from 0 to 20 → still 4 writes, with no restart.
  - Assert `iReset` during EMIT of number 2 → `oWrValid`, `oBusy` and `oDone` are all 0 the next cycle; a fresh `iStart` starts again at `oNum = 1`.

Source files
------------

// File: rtl/chimp_board_loader.sv
// Places numbers 1..N into distinct pseudo-random cells of the 8x8 chimp-test board
// and streams one write command per number to the board datapath.
module chimp_board_loader #(
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int          MIN_COUNT = 4
) (
   input  logic       clk,
   input  logic       iReset,
   input  logic       iStart,
   input  logic [4:0] iLevel,
   input  logic       iWrReady,
   output logic       oWrValid,
   output logic [2:0] oCellX,
   output logic [2:0] oCellY,
   output logic [4:0] oNum,
   output logic       oBusy,
   output logic       oDone
);

   typedef enum logic [2:0] {
      IDLE,
      PICK,
      CHECK,
      EMIT,
      DONE
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [15:0] lfsr;
   logic [15:0] lfsr_next;
   logic [63:0] map;
   logic [5:0]  idx;
   logic [4:0]  num;
   logic [4:0]  count;
   logic [5:0]  level_sum;
   logic [4:0]  count_sat;

   // Cell count saturates at 31 so the probe loop always finds a free cell.
   assign level_sum = {1'b0, iLevel} + 6'(MIN_COUNT);
   assign count_sat = (level_sum > 6'd31) ? 5'd31 : level_sum[4:0];

   assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (iReset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: the default assignment first keeps this combinational block latch-free.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (iStart) state_next = PICK;
         PICK:    state_next = CHECK;
         CHECK:   if (!map[idx]) state_next = EMIT;
         EMIT:    if (iWrReady) state_next = (num == count) ? DONE : PICK;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      oBusy    = (state != IDLE);
      oDone    = (state == DONE);
      oWrValid = (state == EMIT);
   end

   // NOTE: the 64-bit occupancy map is plain flops, so it is reset along with
   // the rest; it is also cleared at the start of every round.
   always_ff @(posedge clk) begin
      if (iReset) begin
         lfsr   <= SEED;
         map    <= '0;
         idx    <= '0;
         num    <= '0;
         count  <= '0;
         oCellX <= '0;
         oCellY <= '0;
         oNum   <= '0;
      end else begin
         lfsr <= lfsr_next;
         case (state)
            IDLE: begin
               if (iStart) begin
                  count <= count_sat;
                  num   <= 5'd1;
                  map   <= '0;
               end
            end
            PICK: idx <= lfsr[5:0];
            CHECK: begin
               if (!map[idx]) begin
                  map[idx] <= 1'b1;
                  oCellX   <= idx[2:0];
                  oCellY   <= idx[5:3];
                  oNum     <= num;
               end else begin
                  idx <= idx + 6'd1;
               end
            end
            EMIT: begin
               if (iWrReady && (num != count)) num <= num + 5'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chimp_board_loader.sv
// Randomised bench for chimp_board_loader: predicts every write (cell, number, cycle)
// from the LFSR sequence and the first-free-cell rule, and checks handshake behaviour.
module tb_chimp_board_loader;

   localparam logic [15:0] SEED      = 16'hACE1;
   localparam int          MIN_COUNT = 4;

   logic       clk = 1'b0;
   logic       iReset;
   logic       iStart;
   logic [4:0] iLevel;
   logic       iWrReady;
   logic       oWrValid;
   logic [2:0] oCellX;
   logic [2:0] oCellY;
   logic [4:0] oNum;
   logic       oBusy;
   logic       oDone;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   logic [15:0] model_lfsr = SEED;

   chimp_board_loader #(.SEED(SEED), .MIN_COUNT(MIN_COUNT)) dut (
      .clk      (clk),
      .iReset   (iReset),
      .iStart   (iStart),
      .iLevel   (iLevel),
      .iWrReady (iWrReady),
      .oWrValid (oWrValid),
      .oCellX   (oCellX),
      .oCellY   (oCellY),
      .oNum     (oNum),
      .oBusy    (oBusy),
      .oDone    (oDone)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] step(input logic [15:0] v);
      logic [15:0] r;
      r = v >> 1;
      if (v[0]) r = r ^ 16'hB400;
      return r;
   endfunction

   // Free-running LFSR reference: value held by the design during the current cycle.
   always @(posedge clk) begin
      model_lfsr <= iReset ? SEED : step(model_lfsr);
      cyc        <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int cnt_for(input int level);
      int c;
      c = level + MIN_COUNT;
      return (c > 31) ? 31 : c;
   endfunction

   // True if a round started now (ready held high) would probe an occupied cell 63.
   function automatic bit wrap_round(input logic [15:0] l_start, input int cnt);
      logic [15:0] l;
      bit [63:0]   occ;
      bit          hit;
      int          c;
      int          d;
      l   = step(l_start);
      occ = '0;
      hit = 1'b0;
      for (int n = 0; n < cnt; n++) begin
         c = int'(l[5:0]);
         d = 0;
         while (occ[c]) begin
            if (c == 63) hit = 1'b1;
            c = (c + 1) % 64;
            d++;
         end
         occ[c] = 1'b1;
         for (int k = 0; k < 3 + d; k++) l = step(l);
      end
      return hit;
   endfunction

   // stall < 0 picks a random stall per write; abort_num > 0 resets during that EMIT.
   task automatic do_round(input int level, input int stall, input bit poke, input int abort_num);
      int          cnt;
      int          p;
      int          c;
      int          d;
      int          e;
      int          wait_n;
      int          st;
      bit [63:0]   occ;
      bit          wrapped;
      logic [10:0] held;
      cnt      = cnt_for(level);
      occ      = '0;
      iLevel   = 5'(level);
      iStart   = 1'b1;
      iWrReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      iStart = 1'b0;
      check("busy_start", oBusy, 1);
      for (int n = 1; n <= cnt; n++) begin
         p       = cyc;
         c       = int'(model_lfsr[5:0]);
         d       = 0;
         wrapped = 1'b0;
         while (occ[c]) begin
            if (c == 63) wrapped = 1'b1;
            c = (c + 1) % 64;
            d++;
         end
         occ[c] = 1'b1;
         e      = p + 2 + d;
         wait_n = 0;
         while (!oWrValid && wait_n < 80) begin
            iWrReady = 1'($urandom_range(0, 1));
            @(negedge clk);
            wait_n++;
         end
         check("valid", oWrValid, 1);
         if (!oWrValid) return;
         check("emit_cycle", cyc, e);
         check(wrapped ? "wrap_cell" : "cell", {oCellY, oCellX}, c);
         check("num", oNum, n);
         check("busy", oBusy, 1);
         if (n == abort_num) begin
            iReset = 1'b1;
            @(negedge clk);
            iReset = 1'b0;
            check("abort_valid", oWrValid, 0);
            check("abort_busy", oBusy, 0);
            check("abort_done", oDone, 0);
            return;
         end
         held = {oCellY, oCellX, oNum};
         st   = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
         if (poke && n == 2 && st == 0) st = 1;
         for (int j = 0; j < st; j++) begin
            iWrReady = 1'b0;
            if (poke && n == 2 && j == 0) begin
               iStart = 1'b1;
               iLevel = 5'd20;
            end
            @(negedge clk);
            iStart = 1'b0;
            check("stall_valid", oWrValid, 1);
            check("stall_data", {oCellY, oCellX, oNum}, held);
         end
         iWrReady = 1'b1;
         @(negedge clk);
         check("drop_valid", oWrValid, 0);
         check("done", oDone, (n == cnt) ? 1 : 0);
      end
      check("busy_done", oBusy, 1);
      iStart   = 1'b1;
      iWrReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      iStart = 1'b0;
      check("idle_busy", oBusy, 0);
      check("done_pulse", oDone, 0);
      @(negedge clk);
      check("ignored_start", oBusy, 0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      iReset   = 1'b1;
      iStart   = 1'b0;
      iWrReady = 1'b0;
      iLevel   = 5'd0;
      repeat (3) @(negedge clk);
      iReset = 1'b0;
      @(negedge clk);
      check("rst_valid", oWrValid, 0);
      check("rst_cellx", oCellX, 0);
      check("rst_celly", oCellY, 0);
      check("rst_num", oNum, 0);
      check("rst_busy", oBusy, 0);
      check("rst_done", oDone, 0);

      do_round(0, 0, 1'b0, 0);
      do_round(30, 0, 1'b0, 0);
      do_round(2, 7, 1'b0, 0);
      do_round(0, 2, 1'b1, 0);

      do_round(0, 0, 1'b0, 2);
      for (int k = 0; k < 4; k++) begin
         iWrReady = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("post_reset_valid", oWrValid, 0);
         check("post_reset_busy", oBusy, 0);
      end
      do_round(0, -1, 1'b0, 0);

      found = 1'b0;
      for (int k = 0; k < 4000 && !found; k++) begin
         if (wrap_round(model_lfsr, 31)) found = 1'b1;
         else @(negedge clk);
      end
      do_round(30, 0, 1'b0, 0);

      repeat (6) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         do_round(int'($urandom_range(0, 31)), -1, 1'b0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
